// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one imem request at a time, hands the word to decode.
// Optional perf counters (fetch_count, stall_cycles) are built only when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          W_ADDR   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [W_ADDR-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [W_ADDR-1:0] imem_rsp_data,
  output logic [W_ADDR-1:0] inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [W_ADDR-1:0] pc,
  output logic [W_ADDR-1:0] pc_plus4,
  input  logic [1:0]        pc_src,
  input  logic [25:0]       jump_addr,
  input  logic [15:0]       imm,
  input  logic              br_taken,
  input  logic [W_ADDR-1:0] jr_target,
  output logic              misalign,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_cycles
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  localparam logic [1:0] SRC_NEXT   = 2'd0;
  localparam logic [1:0] SRC_JUMP   = 2'd1;
  localparam logic [1:0] SRC_BRANCH = 2'd2;
  localparam logic [1:0] SRC_JR     = 2'd3;

  state_t            state, state_nxt;
  logic              rst_done;
  logic              retire;
  logic [W_ADDR-1:0] next_pc;
  logic [W_ADDR-1:0] br_off;

  assign pc_plus4  = pc + W_ADDR'(4);
  assign imem_addr = pc;
  assign br_off    = {{(W_ADDR-18){imm[15]}}, imm, 2'b00};

  // rst_done keeps the request low until the first clock after reset release
  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    retire         = 1'b0;
    case (state)
      S_REQ: begin
        imem_req_valid = rst_done;
        if (rst_done && imem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        retire = inst_valid && inst_ready;
        if (retire) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      SRC_NEXT:   next_pc = pc_plus4;
      SRC_JUMP:   next_pc = {pc_plus4[W_ADDR-1:28], jump_addr, 2'b00};
      SRC_BRANCH: next_pc = br_taken ? (pc_plus4 + br_off) : pc_plus4;
      SRC_JR:     next_pc = {jr_target[W_ADDR-1:2], 2'b00};
      default:    next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_REQ;
      rst_done   <= 1'b0;
      pc         <= RESET_PC[W_ADDR-1:0];
      inst       <= '0;
      inst_valid <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      state    <= state_nxt;
      rst_done <= 1'b1;
      if (state == S_WAIT && imem_rsp_valid) begin
        inst       <= imem_rsp_data;
        inst_valid <= 1'b1;
      end
      if (retire) begin
        inst_valid <= 1'b0;
        pc         <= next_pc;
        if (pc_src == SRC_JR && jr_target[1:0] != 2'b00) misalign <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  logic        stall;

  assign stall = (imem_req_valid && !imem_req_ready) || (state == S_WAIT && !imem_rsp_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (retire) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall)  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign stall_cycles = stall_cnt_q;
`else
  assign fetch_count  = '0;
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected fetch addresses go through a scoreboard queue.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] inst;
  logic        inst_valid, inst_ready;
  logic [31:0] pc, pc_plus4;
  logic [1:0]  pc_src;
  logic [25:0] jump_addr;
  logic [15:0] imm;
  logic        br_taken;
  logic [31:0] jr_target;
  logic        misalign;
  logic [31:0] fetch_count, stall_cycles;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          req_cyc  = 0;
  int          prev_cyc = 0;
  int          n_retire = 0;
  logic [31:0] exp_q[$];
  logic [31:0] held_inst;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .pc(pc), .pc_plus4(pc_plus4), .pc_src(pc_src), .jump_addr(jump_addr), .imm(imm),
    .br_taken(br_taken), .jr_target(jr_target), .misalign(misalign),
    .fetch_count(fetch_count), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full request/response/retire transaction; nxt is the bench's own next-PC prediction.
  task automatic do_fetch(input logic [31:0] word, input logic [1:0] src, input logic [25:0] ja,
                          input logic [15:0] im, input logic bt, input logic [31:0] jr,
                          input logic [31:0] nxt);
    logic [31:0] exp_a;
    int w;
    imem_req_ready = 1'b1;
    w = 0;
    while (imem_req_valid !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("req_seen", {31'b0, imem_req_valid}, 32'd1);
    exp_a = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check("imem_addr", imem_addr, exp_a);
    prev_cyc = req_cyc;
    req_cyc  = cyc;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check("req_drop", {31'b0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    check("inst_valid", {31'b0, inst_valid}, 32'd1);
    check("inst", inst, word);
    check("pc", pc, exp_a);
    check("pc_plus4", pc_plus4, exp_a + 32'd4);
    pc_src = src; jump_addr = ja; imm = im; br_taken = bt; jr_target = jr;
    inst_ready = 1'b1;
    exp_q.push_back(nxt);
    @(negedge clk);
    inst_ready = 1'b0;
    pc_src = 2'd0; br_taken = 1'b0;
    n_retire++;
    check("inst_clear", {31'b0, inst_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0; pc_src = '0; jump_addr = '0; imm = '0; br_taken = 1'b0; jr_target = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_pc", pc, RST_PC);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    check("rst_fetch_count", fetch_count, 32'd0);
    check("rst_stall_cycles", stall_cycles, 32'd0);

    // Release; request rises only after the first clock
    rst_n = 1'b1;
    #1 check("rel_req_low", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    check("rel_req_high", {31'b0, imem_req_valid}, 32'd1);

    // Backpressure: 4 cycles not ready, 3 cycles no response, 2 cycles decode stall
    for (int i = 0; i < 4; i++) begin
      check("stall_addr", imem_addr, RST_PC);
      check("stall_valid", {31'b0, imem_req_valid}, 32'd1);
      @(negedge clk);
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wait_req_low", {31'b0, imem_req_valid}, 32'd0);
      check("wait_inst_valid", {31'b0, inst_valid}, 32'd0);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h2408_0005;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hFFFF_FFFF;
    held_inst = 32'h2408_0005;
    for (int i = 0; i < 2; i++) begin
      check("hold_inst", inst, held_inst);
      check("hold_valid", {31'b0, inst_valid}, 32'd1);
      check("hold_pc", pc, RST_PC);
      @(negedge clk);
    end
    inst_ready = 1'b1;
    pc_src = 2'd0;
    @(negedge clk);
    inst_ready = 1'b0;
    n_retire++;
    check("perf_stall", stall_cycles, PERF ? 32'd7 : 32'd0);
    check("perf_fetch", fetch_count, PERF ? 32'd1 : 32'd0);
    exp_q.push_back(RST_PC + 32'd4);

    // Sequential fetches: one request every 3 cycles
    do_fetch(32'h0000_0001, 2'd0, '0, '0, 1'b0, '0, 32'h0040_0008);
    do_fetch(32'h0000_0002, 2'd0, '0, '0, 1'b0, '0, 32'h0040_000C);
    check("issue_period", req_cyc - prev_cyc, 32'd3);
    do_fetch(32'h0000_0003, 2'd0, '0, '0, 1'b0, '0, 32'h0040_0010);
    check("issue_period2", req_cyc - prev_cyc, 32'd3);

    // Branch taken backwards from 0x00400010
    do_fetch(32'h1000_FFFC, 2'd2, '0, 16'hFFFC, 1'b1, '0, 32'h0040_0004);
    do_fetch(32'h0000_0005, 2'd0, '0, '0, 1'b0, '0, 32'h0040_0008);
    do_fetch(32'h0000_0006, 2'd0, '0, '0, 1'b0, '0, 32'h0040_000C);
    do_fetch(32'h0000_0007, 2'd0, '0, '0, 1'b0, '0, 32'h0040_0010);
    // Branch not taken from 0x00400010
    do_fetch(32'h1000_FFFC, 2'd2, '0, 16'hFFFC, 1'b0, '0, 32'h0040_0014);
    do_fetch(32'h0000_0008, 2'd0, '0, '0, 1'b0, '0, 32'h0040_0018);
    do_fetch(32'h0000_0009, 2'd0, '0, '0, 1'b0, '0, 32'h0040_001C);
    do_fetch(32'h0000_000A, 2'd0, '0, '0, 1'b0, '0, 32'h0040_0020);
    // Jump from 0x00400020
    do_fetch(32'h0810_0008, 2'd1, 26'h010_0008, '0, 1'b0, '0, 32'h0040_0020);
    check("misalign_before_jr", {31'b0, misalign}, 32'd0);
    // Misaligned JR
    do_fetch(32'h0100_0008, 2'd3, '0, '0, 1'b0, 32'h0040_0102, 32'h0040_0100);
    check("misalign_set", {31'b0, misalign}, 32'd1);
    do_fetch(32'h0000_000B, 2'd0, '0, '0, 1'b0, '0, 32'h0040_0104);
    check("misalign_sticky", {31'b0, misalign}, 32'd1);
    check("perf_fetch_total", fetch_count, PERF ? n_retire : 32'd0);

    // Reset while waiting for a response, then a stale response
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check("pre_rst_wait", {31'b0, imem_req_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("mid_rst_pc", pc, RST_PC);
    check("mid_rst_misalign", {31'b0, misalign}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    check("stale_req_low", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    check("stale_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("stale_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("stale_addr", imem_addr, RST_PC);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    check("stale_inst_valid2", {31'b0, inst_valid}, 32'd0);
    check("stale_inst", inst, 32'd0);
    exp_q.delete();
    exp_q.push_back(RST_PC);
    do_fetch(32'h0000_000C, 2'd0, '0, '0, 1'b0, '0, 32'h0040_0004);
    do_fetch(32'h0000_000D, 2'd0, '0, '0, 1'b0, '0, 32'h0040_0008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
